instruction_fetch: RTL and testbench

//  PC register, next-PC/branch resolution and instruction memory for the single-cycle core.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/instruction_rom.sv | 23 ++
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle core: canonical NOP, reset PC and fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_rom.sv
// Instruction memory: one synchronous write port for the loader, one asynchronous read port for fetch.
module instruction_rom #(
  parameter int IMEM_AW = 14
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IMEM_AW-1:0] waddr,
  input  logic [31:0]        wdata,
  input  logic [IMEM_AW-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [31:0] mem [2**IMEM_AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// PC register, branch/jump resolution and instruction memory for the single-cycle core,
// plus a LOAD mode in which the UART loader writes program words into memory.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  input  logic               load_mode,
  input  logic               load_we,
  input  logic [IMEM_AW-1:0] load_addr,
  input  logic [31:0]        load_data,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               branch_lt,
  input  logic               branch_ge,
  input  logic               branch_ltu,
  input  logic               branch_geu,
  input  logic               jal,
  input  logic               jalr,
  input  logic               zero,
  input  logic               lt,
  input  logic               ltu,
  input  logic [31:0]        imm32,
  input  logic [31:0]        rs1_data,
  output logic [31:0]        instruction,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               instr_valid,
  output logic               misalign
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign_q, misalign_d;
  logic         taken;
  logic [31:0]  next_pc;
  logic [31:0]  imem_rdata;

  instruction_rom #(.IMEM_AW(IMEM_AW)) u_rom (
    .clk   (clk),
    .we    (load_we && (state_q == LOAD)),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q[IMEM_AW+1:2]),
    .rdata (imem_rdata)
  );

  assign instr_valid = (state_q == RUN) && run_en;
  assign instruction = instr_valid ? imem_rdata : NOP_INSTR;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign misalign    = misalign_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    next_pc    = pc_q + 32'd4;

    taken = (Branch & zero) | (nBranch & ~zero) | (branch_lt & lt) | (branch_ge & ~lt)
          | (branch_ltu & ltu) | (branch_geu & ~ltu);

    // jalr wins over jal so an illegal double-strobe decode is still deterministic
    if (jalr) begin
      next_pc = (rs1_data + imm32) & ~32'h1;
    end else if (jal || taken) begin
      next_pc = pc_q + imm32;
    end

    misalign_d = instr_valid & next_pc[1];

    case (state_q)
      IDLE: state_d = load_mode ? LOAD : RUN;
      RUN: begin
        if (load_mode) begin
          state_d = LOAD;
        end else if (run_en) begin
          pc_d = next_pc & ~32'h3;
        end
      end
      LOAD: begin
        if (!load_mode) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: reset, load, sequential fetch, stall, branches, jumps, wrap.
module tb_instruction_fetch;

  localparam int IMEM_AW = 14;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic               clk;
  logic               rst_n;
  logic               run_en;
  logic               load_mode;
  logic               load_we;
  logic [IMEM_AW-1:0] load_addr;
  logic [31:0]        load_data;
  logic               Branch, nBranch, branch_lt, branch_ge, branch_ltu, branch_geu;
  logic               jal, jalr, zero, lt, ltu;
  logic [31:0]        imm32, rs1_data;
  logic [31:0]        instruction, pc, pc_plus4;
  logic               instr_valid, misalign;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] prog [6];

  instruction_fetch #(.IMEM_AW(IMEM_AW), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_en      (run_en),
    .load_mode   (load_mode),
    .load_we     (load_we),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .Branch      (Branch),
    .nBranch     (nBranch),
    .branch_lt   (branch_lt),
    .branch_ge   (branch_ge),
    .branch_ltu  (branch_ltu),
    .branch_geu  (branch_geu),
    .jal         (jal),
    .jalr        (jalr),
    .zero        (zero),
    .lt          (lt),
    .ltu         (ltu),
    .imm32       (imm32),
    .rs1_data    (rs1_data),
    .instruction (instruction),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .misalign    (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    Branch = 0; nBranch = 0; branch_lt = 0; branch_ge = 0; branch_ltu = 0; branch_geu = 0;
    jal = 0; jalr = 0; zero = 0; lt = 0; ltu = 0;
    imm32 = 32'h0; rs1_data = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 0; run_en = 1; load_mode = 0; load_we = 0; load_addr = '0; load_data = 32'h0;
    clear_strobes();
    repeat (3) step();
    tests_run++;
    if (pc !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0);
    end
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid);
    end
    tests_run++;
    if (instruction !== NOP) begin
      tests_failed++; $display("[TB] FAIL reset_nop: got %h expected %h", instruction, NOP);
    end
    tests_run++;
    if (misalign !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign);
    end
    rst_n = 1;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bubble_valid: got %b expected 0", instr_valid);
    end
    step();
    tests_run++;
    if (instr_valid !== 1'b1 || pc !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL first_valid: got valid=%b pc=%h expected valid=1 pc=0", instr_valid, pc);
    end
    step();
    tests_run++;
    if (pc !== 32'h4) begin
      tests_failed++; $display("[TB] FAIL first_advance: got %h expected %h", pc, 32'h4);
    end
  endtask

  task automatic test_load();
    load_mode = 1;
    step();
    tests_run++;
    if (pc !== 32'h4 || instr_valid !== 1'b0 || instruction !== NOP) begin
      tests_failed++;
      $display("[TB] FAIL load_enter: got pc=%h valid=%b instr=%h expected pc=4 valid=0 instr=%h", pc, instr_valid, instruction, NOP);
    end
    for (int i = 0; i < 6; i++) begin
      load_we = 1; load_addr = IMEM_AW'(i); load_data = prog[i];
      step();
    end
    load_we = 0;
    tests_run++;
    if (pc !== 32'h4 || instruction !== NOP) begin
      tests_failed++; $display("[TB] FAIL load_frozen: got pc=%h instr=%h expected pc=4 instr=%h", pc, instruction, NOP);
    end
    load_mode = 0;
    step();
    tests_run++;
    if (pc !== 32'h0 || instr_valid !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL load_exit: got pc=%h valid=%b expected pc=0 valid=1", pc, instr_valid);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (pc !== 32'(4 * i) || instruction !== prog[i]) begin
        tests_failed++;
        $display("[TB] FAIL seq_%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, pc, instruction, 32'(4 * i), prog[i]);
      end
      tests_run++;
      if (pc_plus4 !== 32'(4 * i + 4)) begin
        tests_failed++; $display("[TB] FAIL seq_plus4_%0d: got %h expected %h", i, pc_plus4, 32'(4 * i + 4));
      end
      step();
    end
  endtask

  task automatic test_stall();
    run_en = 0;
    #1;
    tests_run++;
    if (instr_valid !== 1'b0 || instruction !== NOP) begin
      tests_failed++; $display("[TB] FAIL stall_nop: got valid=%b instr=%h expected valid=0 instr=%h", instr_valid, instruction, NOP);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (pc !== 32'h14) begin
        tests_failed++; $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, pc, 32'h14);
      end
    end
    run_en = 1;
    #1;
    tests_run++;
    if (instruction !== 32'hDEAD_BEEF) begin
      tests_failed++; $display("[TB] FAIL stall_resume_instr: got %h expected %h", instruction, 32'hDEAD_BEEF);
    end
    step();
    tests_run++;
    if (pc !== 32'h18) begin
      tests_failed++; $display("[TB] FAIL stall_resume_pc: got %h expected %h", pc, 32'h18);
    end
  endtask

  task automatic test_branch();
    clear_strobes(); jal = 1; imm32 = 32'hFFFF_FFF8;
    step();
    tests_run++;
    if (pc !== 32'h10) begin
      tests_failed++; $display("[TB] FAIL jal_back: got %h expected %h", pc, 32'h10);
    end
    clear_strobes(); Branch = 1; zero = 1; imm32 = 32'hFFFF_FFF8;
    step();
    tests_run++;
    if (pc !== 32'h08) begin
      tests_failed++; $display("[TB] FAIL beq_taken: got %h expected %h", pc, 32'h08);
    end
    clear_strobes(); jal = 1; imm32 = 32'h8;
    step();
    clear_strobes(); Branch = 1; zero = 0; imm32 = 32'hFFFF_FFF8;
    step();
    tests_run++;
    if (pc !== 32'h14) begin
      tests_failed++; $display("[TB] FAIL beq_not_taken: got %h expected %h", pc, 32'h14);
    end
    clear_strobes(); branch_geu = 1; ltu = 0; imm32 = 32'h20;
    step();
    tests_run++;
    if (pc !== 32'h34) begin
      tests_failed++; $display("[TB] FAIL bgeu_taken: got %h expected %h", pc, 32'h34);
    end
    clear_strobes(); branch_lt = 1; lt = 0; imm32 = 32'h20;
    step();
    tests_run++;
    if (pc !== 32'h38) begin
      tests_failed++; $display("[TB] FAIL blt_not_taken: got %h expected %h", pc, 32'h38);
    end
    clear_strobes(); nBranch = 1; zero = 0; imm32 = 32'hFFFF_FFC8;
    step();
    tests_run++;
    if (pc !== 32'h00 || misalign !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL bne_taken: got pc=%h misalign=%b expected pc=0 misalign=0", pc, misalign);
    end
    clear_strobes();
  endtask

  task automatic test_jalr();
    clear_strobes(); jalr = 1; rs1_data = 32'h103; imm32 = 32'h2;
    step();
    tests_run++;
    if (pc !== 32'h104 || misalign !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL jalr_bit0: got pc=%h misalign=%b expected pc=104 misalign=0", pc, misalign);
    end
    clear_strobes(); jalr = 1; jal = 1; rs1_data = 32'h100; imm32 = 32'h2;
    step();
    tests_run++;
    if (pc !== 32'h100 || misalign !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL jalr_misalign: got pc=%h misalign=%b expected pc=100 misalign=1", pc, misalign);
    end
    clear_strobes();
    step();
    tests_run++;
    if (pc !== 32'h104 || misalign !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL misalign_pulse: got pc=%h misalign=%b expected pc=104 misalign=0", pc, misalign);
    end
  endtask

  task automatic test_wrap();
    clear_strobes(); jalr = 1; rs1_data = 32'hFFFF_FFFC; imm32 = 32'h0;
    step();
    tests_run++;
    if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL wrap_setup: got pc=%h plus4=%h expected pc=fffffffc plus4=0", pc, pc_plus4);
    end
    clear_strobes();
    step();
    tests_run++;
    if (pc !== 32'h0 || instruction !== prog[0]) begin
      tests_failed++; $display("[TB] FAIL wrap: got pc=%h instr=%h expected pc=0 instr=%h", pc, instruction, prog[0]);
    end
  endtask

  initial begin
    prog[0] = 32'h0010_0093;
    prog[1] = 32'h0020_0113;
    prog[2] = 32'h0030_8193;
    prog[3] = 32'h0041_0213;
    prog[4] = 32'h1234_5678;
    prog[5] = 32'hDEAD_BEEF;
    test_reset();
    test_load();
    test_sequential();
    test_stall();
    test_branch();
    test_jalr();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
